j1_uart_io: RTL and testbench

// Responder on the J1 core's I/O bus: decodes io_wr/mem_addr/dout from the core and drives io_din back.

---
 rtl/j1_uart_io_pkg.sv | 39 +++
 rtl/j1_byte_fifo.sv | 56 +++++
 rtl/j1_uart_io.sv | 268 ++++++++++++++++++++++++++
 tb/tb_j1_uart_io.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_uart_io_pkg.sv
// Shared definitions for the J1 I/O responder: register offsets, status bit
// positions and the UART state encodings.
package j1_uart_io_pkg;

   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_TICKS  = 4'h8;

   localparam int ST_TX_NOT_FULL  = 0;
   localparam int ST_RX_VALID     = 1;
   localparam int ST_TX_IDLE      = 2;
   localparam int ST_RX_OVERRUN   = 3;
   localparam int ST_RX_FRAME_ERR = 4;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   // Line level the serializer drives while sitting in a given state.
   function automatic logic tx_line(tx_state_t s, logic lsb);
      case (s)
         TX_START: return 1'b0;
         TX_DATA:  return lsb;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/j1_byte_fifo.sv
// Byte-wide synchronous FIFO with show-ahead read data; a push is accepted only
// when the FIFO is not full at the start of the cycle.
module j1_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       push,
   input  logic [7:0] din,
   output logic       full,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/j1_uart_io.sv
// J1 I/O-bus responder: 8N1 UART (queued TX, single-byte RX holding register)
// plus a free-running tick counter, all read back combinationally on io_din.
module j1_uart_io
   import j1_uart_io_pkg::*;
#(
   parameter int          WIDTH        = 32,
   parameter logic [15:0] IO_BASE      = 16'h1000,
   parameter int          CLKS_PER_BIT = 417,
   parameter int          TX_DEPTH     = 16
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             io_wr,
   input  logic [15:0]      mem_addr,
   input  logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] io_din,
   output logic             uart_tx,
   input  logic             uart_rx
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

   logic       sel;
   logic [3:0] off;
   logic       wr_data, wr_status, wr_ticks;

   assign sel       = (mem_addr[15:4] == IO_BASE[15:4]);
   assign off       = mem_addr[3:0];
   assign wr_data   = io_wr & sel & (off == OFF_DATA);
   assign wr_status = io_wr & sel & (off == OFF_STATUS);
   assign wr_ticks  = io_wr & sel & (off == OFF_TICKS);

   logic       fifo_full, fifo_empty, fifo_pop;
   logic [7:0] fifo_dout;

   j1_byte_fifo #(.DEPTH(TX_DEPTH)) u_txq (
      .clk   (clk),
      .resetq(resetq),
      .push  (wr_data),
      .din   (dout[7:0]),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   // ---------------- TX serializer ----------------
   tx_state_t     tx_state_q, tx_state_d;
   logic [BW-1:0] tx_baud_q, tx_baud_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          uart_tx_q, uart_tx_d;
   logic          tx_baud_done, tx_idle;

   assign tx_baud_done = (tx_baud_q == BAUD_LAST);
   assign tx_idle      = fifo_empty & (tx_state_q == TX_IDLE);
   assign uart_tx      = uart_tx_q;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_state_q <= TX_IDLE;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         uart_tx_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         uart_tx_q  <= uart_tx_d;
      end
   end

   always_ff @(posedge clk) begin
      tx_shift_q <= tx_shift_d;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               tx_state_d = TX_START;
               tx_baud_d  = '0;
               tx_shift_d = fifo_dout;
            end
         end
         TX_START: begin
            tx_baud_d = tx_baud_q + 1'b1;
            if (tx_baud_done) begin
               tx_state_d = TX_DATA;
               tx_baud_d  = '0;
               tx_bit_d   = '0;
            end
         end
         TX_DATA: begin
            tx_baud_d = tx_baud_q + 1'b1;
            if (tx_baud_done) begin
               tx_baud_d  = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 1'b1;
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            tx_baud_d = tx_baud_q + 1'b1;
            if (tx_baud_done) begin
               tx_baud_d = '0;
               // Chain straight into the next start bit when more bytes wait.
               if (!fifo_empty) begin
                  tx_state_d = TX_START;
                  tx_shift_d = fifo_dout;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      fifo_pop  = ~fifo_empty &
                  ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_baud_done));
      uart_tx_d = tx_line(tx_state_d, tx_shift_d[0]);
   end

   // ---------------- RX deserializer ----------------
   logic          rx_meta_q, rx_sync_q;
   rx_state_t     rx_state_q, rx_state_d;
   logic [BW-1:0] rx_baud_q, rx_baud_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_baud_done, rx_stop_sample, rx_done, rx_ferr;

   assign rx_baud_done = (rx_baud_q == BAUD_LAST);

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
      end else begin
         rx_meta_q  <= uart_rx;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
      end
   end

   always_ff @(posedge clk) begin
      rx_shift_q <= rx_shift_d;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_sync_q) begin
               rx_state_d = RX_START;
               rx_baud_d  = '0;
            end
         end
         RX_START: begin
            rx_baud_d = rx_baud_q + 1'b1;
            // Mid-start-bit re-check rejects short glitches.
            if (rx_baud_q == BAUD_HALF) begin
               rx_baud_d  = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            rx_baud_d = rx_baud_q + 1'b1;
            if (rx_baud_done) begin
               rx_baud_d  = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            rx_baud_d = rx_baud_q + 1'b1;
            if (rx_baud_done) begin
               rx_baud_d  = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_stop_sample = (rx_state_q == RX_STOP) & rx_baud_done;
      rx_done        = rx_stop_sample & rx_sync_q;
      rx_ferr        = rx_stop_sample & ~rx_sync_q;
   end

   // ---------------- RX flags, holding register, ticks ----------------
   logic             rx_valid_q, rx_valid_d;
   logic             overrun_q, overrun_d;
   logic             ferr_q, ferr_d;
   logic [7:0]       rx_hold_q, rx_hold_d;
   logic [WIDTH-1:0] ticks_q, ticks_d;
   logic             pop_req, rx_load;

   assign pop_req = wr_status & dout[ST_RX_VALID];
   // A pop in the completion cycle frees the holder for the new byte.
   assign rx_load = rx_done & (~rx_valid_q | pop_req);

   always_comb begin
      rx_hold_d  = rx_load ? rx_shift_q : rx_hold_q;
      rx_valid_d = rx_load ? 1'b1 : (pop_req ? 1'b0 : rx_valid_q);
      overrun_d  = (rx_done & rx_valid_q & ~pop_req) ? 1'b1 :
                   ((wr_status & dout[ST_RX_OVERRUN]) ? 1'b0 : overrun_q);
      ferr_d     = rx_ferr ? 1'b1 :
                   ((wr_status & dout[ST_RX_FRAME_ERR]) ? 1'b0 : ferr_q);
      ticks_d    = wr_ticks ? dout : ticks_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_hold_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         ferr_q     <= 1'b0;
         ticks_q    <= '0;
      end else begin
         rx_hold_q  <= rx_hold_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         ferr_q     <= ferr_d;
         ticks_q    <= ticks_d;
      end
   end

   always_comb begin
      io_din = '0;
      if (sel) begin
         case (off)
            OFF_DATA:   io_din[7:0] = rx_hold_q;
            OFF_STATUS: begin
               io_din[ST_TX_NOT_FULL]  = ~fifo_full;
               io_din[ST_RX_VALID]     = rx_valid_q;
               io_din[ST_TX_IDLE]      = tx_idle;
               io_din[ST_RX_OVERRUN]   = overrun_q;
               io_din[ST_RX_FRAME_ERR] = ferr_q;
            end
            OFF_TICKS:  io_din = ticks_q;
            default:    io_din = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_j1_uart_io.sv
// Bench for j1_uart_io: a frame-timing model of the UART/tick registers checked
// every cycle, plus directed reads with hand-computed values.
module tb_j1_uart_io;

   localparam int C     = 4;
   localparam int DEPTH = 4;

   logic        clk      = 1'b0;
   logic        resetq   = 1'b0;
   logic        io_wr    = 1'b0;
   logic [15:0] mem_addr = 16'h1004;
   logic [31:0] dout     = '0;
   logic [31:0] io_din;
   logic        uart_tx;
   logic        uart_rx  = 1'b1;

   always #5 clk = ~clk;

   j1_uart_io #(
      .WIDTH       (32),
      .IO_BASE     (16'h1000),
      .CLKS_PER_BIT(C),
      .TX_DEPTH    (DEPTH)
   ) dut (
      .clk     (clk),
      .resetq  (resetq),
      .io_wr   (io_wr),
      .mem_addr(mem_addr),
      .dout    (dout),
      .io_din  (io_din),
      .uart_tx (uart_tx),
      .uart_rx (uart_rx)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  m_q[$];
   bit          m_active = 0;
   int          m_t      = 0;
   logic [7:0]  m_byte   = '0;
   logic [31:0] m_ticks  = '0;
   logic [7:0]  m_hold   = '0;
   bit          m_valid  = 0;
   bit          m_ovr    = 0;
   bit          m_fe     = 0;
   bit          rx_mask  = 0;

   function automatic bit frame_bit(logic [7:0] b, int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      return 1'b1;
   endfunction

   always @(posedge clk or negedge resetq) begin : model
      int pre;
      bit win;
      if (!resetq) begin
         m_q.delete();
         m_active = 0;
         m_t      = 0;
         m_ticks  = '0;
         m_hold   = '0;
         m_valid  = 0;
         m_ovr    = 0;
         m_fe     = 0;
      end else begin
         win = (mem_addr[15:4] == 12'h100);
         pre = m_q.size();
         if (m_active) begin
            m_t++;
            if (m_t == 10 * C) m_active = 0;
         end
         if (!m_active && m_q.size() > 0) begin
            m_byte   = m_q.pop_front();
            m_active = 1;
            m_t      = 0;
         end
         if (io_wr && win && mem_addr[3:0] == 4'h0 && pre < DEPTH) m_q.push_back(dout[7:0]);
         if (io_wr && win && mem_addr[3:0] == 4'h4) begin
            if (dout[1]) m_valid = 0;
            if (dout[3]) m_ovr = 0;
            if (dout[4]) m_fe = 0;
         end
         m_ticks = (io_wr && win && mem_addr[3:0] == 4'h8) ? dout : m_ticks + 32'd1;
      end
   end

   always @(negedge clk) begin : cmp
      logic [31:0] e, msk;
      check("uart_tx", {31'b0, uart_tx}, {31'b0, (m_active ? frame_bit(m_byte, m_t / C) : 1'b1)});
      e   = '0;
      msk = '1;
      if (mem_addr[15:4] == 12'h100) begin
         case (mem_addr[3:0])
            4'h0: begin
               e = {24'b0, m_hold};
               if (rx_mask) msk = '0;
            end
            4'h4: begin
               e = {27'b0, m_fe, m_ovr, (!m_active && m_q.size() == 0), m_valid, (m_q.size() < DEPTH)};
               if (rx_mask) msk = 32'h5;
            end
            4'h8: e = m_ticks;
            default: e = '0;
         endcase
      end
      if (msk != '0) check("io_din", io_din & msk, e & msk);
   end

   // Serial decoder on uart_tx, sampling at bit centres.
   logic [7:0] tx_seen[$];
   initial begin
      forever begin
         @(negedge clk);
         if (resetq && uart_tx === 1'b0) begin : frame
            logic [7:0] b;
            logic       stop_bit;
            repeat (C / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (C) @(negedge clk);
               b[k] = uart_tx;
            end
            repeat (C) @(negedge clk);
            stop_bit = uart_tx;
            if (stop_bit) tx_seen.push_back(b);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      mem_addr = a;
      dout     = d;
      io_wr    = 1'b1;
      tick(1);
      io_wr    = 1'b0;
   endtask

   task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
      mem_addr = a;
      #1;
      check(name, io_din, exp);
   endtask

   task automatic send_rx(input logic [7:0] b, input bit stop);
      rx_mask = 1;
      uart_rx = 1'b0;
      tick(C);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(C);
      end
      uart_rx = stop;
      tick(C);
      uart_rx = 1'b1;
      tick(6);
      if (!stop) m_fe = 1;
      else if (!m_valid) begin
         m_hold  = b;
         m_valid = 1;
      end else m_ovr = 1;
      rx_mask = 0;
   endtask

   bit exp_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] exp_bytes[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   initial begin
      // reset state
      tick(3);
      rd("rst_status", 16'h1004, 32'h5);
      rd("rst_data", 16'h1000, 32'h0);
      rd("rst_ticks", 16'h1008, 32'h0);
      check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
      resetq = 1'b1;
      tick(1);
      rd("status_idle", 16'h1004, 32'h5);
      rd("out_of_window", 16'h2000, 32'h0);
      rd("unused_offset", 16'h100C, 32'h0);

      // single frame 0xA5
      tx_seen.delete();
      wr(16'h1000, 32'h1A5);
      mem_addr = 16'h1004;
      tick(3);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("a5_bit%0d", k), {31'b0, uart_tx}, {31'b0, exp_bits[k]});
         if (k == 4) rd("status_busy", 16'h1004, 32'h1);
         tick(C);
      end
      rd("status_after_frame", 16'h1004, 32'h5);
      check("a5_frames", tx_seen.size(), 1);
      if (tx_seen.size() > 0) check("a5_byte", {24'b0, tx_seen[0]}, 32'hA5);

      // queue overflow while busy
      tx_seen.delete();
      wr(16'h1000, 32'h11);
      tick(2);
      wr(16'h1000, 32'h22);
      wr(16'h1000, 32'h33);
      wr(16'h1000, 32'h44);
      wr(16'h1000, 32'h55);
      wr(16'h1000, 32'h66);
      rd("status_full", 16'h1004, 32'h0);
      tick(5 * 10 * C + 20);
      check("burst_frames", tx_seen.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < tx_seen.size()) check($sformatf("burst_byte%0d", i), {24'b0, tx_seen[i]}, {24'b0, exp_bytes[i]});
      rd("status_drained", 16'h1004, 32'h5);

      // receive, overrun, clear
      send_rx(8'h3C, 1'b1);
      rd("rx_status", 16'h1004, 32'h7);
      rd("rx_data", 16'h1000, 32'h3C);
      send_rx(8'h99, 1'b1);
      rd("ovr_status", 16'h1004, 32'hF);
      rd("ovr_data", 16'h1000, 32'h3C);
      wr(16'h1004, 32'hA);
      rd("clr_status", 16'h1004, 32'h5);

      // framing error, glitch
      send_rx(8'h5A, 1'b0);
      rd("ferr_status", 16'h1004, 32'h15);
      rd("ferr_data", 16'h1000, 32'h3C);
      wr(16'h1004, 32'h10);
      rd("ferr_clr", 16'h1004, 32'h5);
      uart_rx = 1'b0;
      tick(1);
      uart_rx = 1'b1;
      tick(10);
      rd("glitch_status", 16'h1004, 32'h5);
      send_rx(8'h81, 1'b1);
      rd("post_glitch_status", 16'h1004, 32'h7);
      rd("post_glitch_data", 16'h1000, 32'h81);

      // tick counter load and wrap
      wr(16'h1008, 32'hFFFF_FFFE);
      rd("ticks_load", 16'h1008, 32'hFFFF_FFFE);
      tick(1);
      rd("ticks_max", 16'h1008, 32'hFFFF_FFFF);
      tick(1);
      rd("ticks_wrap", 16'h1008, 32'h0);

      // reset in the middle of a start bit
      wr(16'h1000, 32'h0F);
      tick(1);
      check("tx_start_low", {31'b0, uart_tx}, 32'h0);
      tick(1);
      resetq = 1'b0;
      #1;
      check("tx_reset_high", {31'b0, uart_tx}, 32'h1);
      rd("reset_status", 16'h1004, 32'h5);
      rd("reset_data", 16'h1000, 32'h0);
      rd("reset_ticks", 16'h1008, 32'h0);
      tick(2);
      resetq = 1'b1;
      tick(3);
      rd("ticks_after_reset", 16'h1008, 32'h3);
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
